// File: rtl/tof_plot_fb.sv
// tof_plot_fb: multi-bit ToF plot framebuffer.
// Plot writes are two-cycle read-modify-write ops (overwrite, saturating add,
// max, erase) behind a valid/ready handshake. A sweep engine clears the whole
// frame, and optionally decays it. A separate registered read port serves
// scan-out. Everything runs on clk.
//
// Handshake: a write is accepted on a rising edge where wr_valid && wr_ready.
// wr_ready is low while a sweep runs, during the write phase of an op, and
// whenever a sweep start is presented, so a start always beats a write.
//
// Build option: define TOF_PLOT_FB_DECAY_EN to build the decay sweep
// (decay_start, DECAY_RD/DECAY_WR states). Without it decay_start is ignored.
module tof_plot_fb #(
  parameter int X_W   = 8,
  parameter int Y_W   = 8,
  parameter int PIX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [X_W-1:0]   wr_x,
  input  logic [Y_W-1:0]   wr_y,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [1:0]       wr_mode,
  input  logic             rd_en,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             clr_start,
  input  logic             decay_start,
  output logic             busy,
  output logic             sweep_done,
  output logic [2:0]       dbg_state
);

  localparam int A_W = X_W + Y_W;
  localparam logic [A_W-1:0]   LAST = '1;
  localparam logic [PIX_W-1:0] PMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
`ifdef TOF_PLOT_FB_DECAY_EN
    S_DECAY_RD = 3'd2,
    S_DECAY_WR = 3'd3,
`endif
    S_DONE     = 3'd4
  } state_t;

  state_t           state;
  logic [A_W-1:0]   cnt;
  logic             phase_w;
  logic [A_W-1:0]   op_addr;
  logic [PIX_W-1:0] op_data;
  logic [1:0]       op_mode;
  logic [PIX_W-1:0] rmw_q;
  logic [PIX_W-1:0] op_new;
  logic [PIX_W:0]   sum;
  logic             wr_acc;
  logic             decay_go;
  logic             mem_we;
  logic [A_W-1:0]   mem_wa;
  logic [PIX_W-1:0] mem_wd;

  logic [PIX_W-1:0] mem [0:(1<<A_W)-1];

`ifdef TOF_PLOT_FB_DECAY_EN
  assign decay_go = decay_start;
`else
  logic unused_decay;
  assign unused_decay = decay_start;
  assign decay_go     = 1'b0;
`endif

  assign wr_ready  = !busy && !phase_w && !clr_start && !decay_go;
  assign wr_acc    = wr_valid && wr_ready;
  assign dbg_state = state;

  // Write path: capture operands on accept, flag the following write phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_w <= 1'b0;
      op_addr <= '0;
      op_data <= '0;
      op_mode <= 2'b00;
    end else begin
      phase_w <= wr_acc;
      if (wr_acc) begin
        op_addr <= {wr_y, wr_x};
        op_data <= wr_data;
        op_mode <= wr_mode;
      end
    end
  end

  // Internal read for read-modify-write (plot op or decay step).
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      rmw_q <= mem[{wr_y, wr_x}];
    end
`ifdef TOF_PLOT_FB_DECAY_EN
    else if (state == S_DECAY_RD) begin
      rmw_q <= mem[cnt];
    end
`endif
  end

  // Combine the old pixel with the operand according to the latched mode.
  always_comb begin
    sum = {1'b0, rmw_q} + {1'b0, op_data};
    op_new = '0;
    case (op_mode)
      2'b00:   op_new = op_data;
      2'b01:   op_new = (sum > {1'b0, PMAX}) ? PMAX : sum[PIX_W-1:0];
      2'b10:   op_new = (rmw_q > op_data) ? rmw_q : op_data;
      default: op_new = '0;
    endcase
  end

  // Single memory write port: plot write phase or sweep write.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (phase_w) begin
      mem_we = 1'b1;
      mem_wa = op_addr;
      mem_wd = op_new;
    end else if (state == S_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = cnt;
    end
`ifdef TOF_PLOT_FB_DECAY_EN
    else if (state == S_DECAY_WR) begin
      mem_we = 1'b1;
      mem_wa = cnt;
      mem_wd = (rmw_q == '0) ? '0 : rmw_q - PIX_W'(1);
    end
`endif
  end

  // Frame store write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Scan-out read port: one-cycle latency, read-first, data held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[{rd_y, rd_x}];
      end
    end
  end

  // Sweep FSM with registered busy / sweep_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sweep_done <= 1'b0;
          if (!phase_w && clr_start) begin
            state <= S_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
`ifdef TOF_PLOT_FB_DECAY_EN
          else if (!phase_w && decay_go) begin
            state <= S_DECAY_RD;
            cnt   <= '0;
            busy  <= 1'b1;
          end
`endif
        end
        S_CLEAR: begin
          if (cnt == LAST) begin
            state      <= S_DONE;
            cnt        <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
          end else begin
            cnt <= cnt + A_W'(1);
          end
        end
`ifdef TOF_PLOT_FB_DECAY_EN
        S_DECAY_RD: begin
          state <= S_DECAY_WR;
        end
        S_DECAY_WR: begin
          if (cnt == LAST) begin
            state      <= S_DONE;
            cnt        <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
          end else begin
            state <= S_DECAY_RD;
            cnt   <= cnt + A_W'(1);
          end
        end
`endif
        S_DONE: begin
          sweep_done <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          sweep_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tof_plot_fb.sv
// Bench for tof_plot_fb, built with a reduced 128x64 frame so that every
// sweep fits comfortably in a short run.
module tb_tof_plot_fb;

  localparam int X_W   = 7;
  localparam int Y_W   = 6;
  localparam int PIX_W = 4;
  localparam int DEPTH = 1 << (X_W + Y_W);

  // Clock / reset and DUT signals
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [X_W-1:0]   wr_x = '0;
  logic [Y_W-1:0]   wr_y = '0;
  logic [PIX_W-1:0] wr_data = '0;
  logic [1:0]       wr_mode = 2'b00;
  logic             rd_en = 1'b0;
  logic [X_W-1:0]   rd_x = '0;
  logic [Y_W-1:0]   rd_y = '0;
  logic [PIX_W-1:0] rd_data;
  logic             rd_valid;
  logic             clr_start = 1'b0;
  logic             decay_start = 1'b0;
  logic             busy;
  logic             sweep_done;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  tof_plot_fb #(.X_W(X_W), .Y_W(Y_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_mode(wr_mode),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .decay_start(decay_start),
    .busy(busy), .sweep_done(sweep_done), .dbg_state(dbg_state)
  );

  // Scoreboard: reference picture of the frame plus counters
  logic [PIX_W-1:0] ref_mem [0:DEPTH-1];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [PIX_W-1:0] model_op(input int old, input int d, input int m);
    int s;
    case (m)
      0:       s = d;
      1:       s = (old + d > 15) ? 15 : old + d;
      2:       s = (old > d) ? old : d;
      default: s = 0;
    endcase
    return PIX_W'(s);
  endfunction

  function automatic int addr_of(input int x, input int y);
    return y * (1 << X_W) + x;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input int x, input int y, input int d, input int m);
    int guard;
    guard = 0;
    wr_x = X_W'(x); wr_y = Y_W'(y); wr_data = PIX_W'(d); wr_mode = 2'(m);
    wr_valid = 1'b1;
    while (!wr_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!wr_ready) begin
      vectors++; miscompares++;
      $display("FAIL write_accept_timeout x=%0d y=%0d wr_ready=%b required 1", x, y, wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    ref_mem[addr_of(x, y)] = model_op(ref_mem[addr_of(x, y)], d, m);
    tick();
  endtask

  task automatic do_read(input int x, input int y, output logic [PIX_W-1:0] d, output logic v);
    rd_x = X_W'(x); rd_y = Y_W'(y); rd_en = 1'b1;
    tick();
    d = rd_data; v = rd_valid;
    rd_en = 1'b0;
  endtask

  // Monitors a running sweep until sweep_done, with an optional stray clr_start.
  task automatic wait_sweep(input int pulse_at, output int cyc, output bit seen,
                            output bit busy_at_done, output bit rdy_leak);
    cyc = 0; seen = 1'b0; busy_at_done = 1'b1; rdy_leak = 1'b0;
    if (busy) cyc++;
    for (int k = 0; k < 4 * DEPTH && !seen; k++) begin
      clr_start = (k == pulse_at);
      tick();
      clr_start = 1'b0;
      if (sweep_done) begin
        seen = 1'b1;
        busy_at_done = busy;
      end else begin
        if (busy) cyc++;
        if (wr_ready) rdy_leak = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (busy !== 1'b0 || sweep_done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs busy=%b done=%b rd_valid=%b rd_data=%0d required 0 0 0 0",
               busy, sweep_done, rd_valid, rd_data);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (wr_ready !== 1'b1 || dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release wr_ready=%b state=%0d required 1 0", wr_ready, dbg_state);
    end
  endtask

  task automatic test_clear();
    int cyc; bit seen, bad, leak;
    logic [PIX_W-1:0] d; logic v;
    int pts [3][2];
    pts = '{'{0, 0}, '{127, 63}, '{17, 50}};
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wait_sweep(-1, cyc, seen, bad, leak);
    vectors++;
    if (!seen || cyc != DEPTH || bad !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_duration done_seen=%0d busy_cycles=%0d busy_at_done=%b required 1 %0d 0",
               seen, cyc, bad, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < 3; i++) begin
      do_read(pts[i][0], pts[i][1], d, v);
      vectors++;
      if (d !== 4'd0 || v !== 1'b1) begin
        miscompares++;
        $display("FAIL clear_read (%0d,%0d) rd_data=%0d rd_valid=%b required 0 1",
                 pts[i][0], pts[i][1], d, v);
      end
    end
    tick();
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_valid_strobe rd_valid=%b required 0", rd_valid);
    end
  endtask

  task automatic test_modes();
    int ops [5][3];
    logic [PIX_W-1:0] d; logic v;
    // {mode, operand, expected}
    ops = '{'{0, 9, 9}, '{1, 4, 13}, '{1, 7, 15}, '{2, 2, 15}, '{3, 5, 0}};
    for (int i = 0; i < 5; i++) begin
      drive_write(3, 5, ops[i][1], ops[i][0]);
      do_read(3, 5, d, v);
      vectors++;
      if (d !== PIX_W'(ops[i][2]) || d !== ref_mem[addr_of(3, 5)]) begin
        miscompares++;
        $display("FAIL mode_%0d operand=%0d rd_data=%0d required %0d", ops[i][0], ops[i][1], d, ops[i][2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a;
    a = addr_of(40, 20);
    drive_write(40, 20, 0, 3);
    rd_x = X_W'(40); rd_y = Y_W'(20); rd_en = 1'b1;
    wr_x = X_W'(40); wr_y = Y_W'(20); wr_data = 4'd1; wr_mode = 2'b01;
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (wr_ready !== ((i % 2) == 0)) begin
        miscompares++;
        $display("FAIL handshake_ready cycle=%0d wr_ready=%b required %0d", i, wr_ready, (i % 2) == 0);
      end
      tick();
      // reads are read-first: a write on the same edge is not yet visible
      vectors++;
      if (rd_data !== PIX_W'(i / 2)) begin
        miscompares++;
        $display("FAIL b2b_progress cycle=%0d rd_data=%0d required %0d", i, rd_data, i / 2);
      end
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[a] = model_op(ref_mem[a], 1, 1);
    tick();
    rd_en = 1'b0;
    vectors++;
    if (rd_data !== ref_mem[a] || rd_data !== 4'd4) begin
      miscompares++;
      $display("FAIL b2b_final rd_data=%0d required %0d", rd_data, ref_mem[a]);
    end
  endtask

  task automatic test_random();
    int px [6]; int py [6];
    int k, m, dv;
    logic [PIX_W-1:0] d; logic v;
    for (int i = 0; i < 6; i++) begin
      px[i] = $urandom_range(0, 127);
      py[i] = $urandom_range(0, 63);
    end
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 5);
      m = $urandom_range(0, 3);
      dv = $urandom_range(0, 15);
      drive_write(px[k], py[k], dv, m);
      do_read(px[k], py[k], d, v);
      vectors++;
      if (d !== ref_mem[addr_of(px[k], py[k])]) begin
        miscompares++;
        $display("FAIL random_op i=%0d (%0d,%0d) mode=%0d operand=%0d rd_data=%0d required %0d",
                 i, px[k], py[k], m, dv, d, ref_mem[addr_of(px[k], py[k])]);
      end
    end
  endtask

  task automatic test_priority();
    int cyc; bit seen, bad, leak;
    logic [PIX_W-1:0] d; logic v;
    wr_x = X_W'(9); wr_y = Y_W'(9); wr_data = 4'd7; wr_mode = 2'b00;
    wr_valid = 1'b1;
    clr_start = 1'b1;
    #1;
    vectors++;
    if (wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL start_blocks_write wr_ready=%b required 0", wr_ready);
    end
    tick();
    clr_start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_on_start busy=%b wr_ready=%b required 1 0", busy, wr_ready);
    end
    wait_sweep(100, cyc, seen, bad, leak);
    vectors++;
    if (!seen || cyc != DEPTH || bad !== 1'b0 || leak !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_restart_ignored done_seen=%0d busy_cycles=%0d busy_at_done=%b ready_leak=%b required 1 %0d 0 0",
               seen, cyc, bad, leak, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_sweep wr_ready=%b required 1", wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    ref_mem[addr_of(9, 9)] = model_op(0, 7, 0);
    tick();
    do_read(9, 9, d, v);
    vectors++;
    if (d !== ref_mem[addr_of(9, 9)]) begin
      miscompares++;
      $display("FAIL held_write_after_clear rd_data=%0d required %0d", d, ref_mem[addr_of(9, 9)]);
    end
  endtask

  task automatic test_decay();
    int xs [4]; int vs [4];
    logic [PIX_W-1:0] d; logic v;
    xs = '{100, 101, 102, 103};
    vs = '{0, 1, 15, 9};
    for (int i = 0; i < 4; i++) drive_write(xs[i], 30, vs[i], 0);
    decay_start = 1'b1;
    #1;
`ifdef TOF_PLOT_FB_DECAY_EN
    begin
      int cyc; bit seen, bad, leak;
      int ra;
      vectors++;
      if (wr_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL decay_start_blocks_write wr_ready=%b required 0", wr_ready);
      end
      tick();
      decay_start = 1'b0;
      wait_sweep(-1, cyc, seen, bad, leak);
      vectors++;
      if (!seen || cyc != 2 * DEPTH || bad !== 1'b0) begin
        miscompares++;
        $display("FAIL decay_duration done_seen=%0d busy_cycles=%0d required 1 %0d", seen, cyc, 2 * DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = (ref_mem[i] == 0) ? 4'd0 : ref_mem[i] - 4'd1;
      for (int i = 0; i < 6; i++) begin
        ra = (i < 4) ? addr_of(xs[i], 30) : $urandom_range(0, DEPTH - 1);
        do_read(ra % (1 << X_W), ra / (1 << X_W), d, v);
        vectors++;
        if (d !== ref_mem[ra]) begin
          miscompares++;
          $display("FAIL decay_pixel addr=%0d rd_data=%0d required %0d", ra, d, ref_mem[ra]);
        end
      end
    end
`else
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL decay_ignored_ready wr_ready=%b required 1", wr_ready);
    end
    tick();
    decay_start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL decay_ignored_busy busy=%b required 0", busy);
    end
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      do_read(xs[i], 30, d, v);
      vectors++;
      if (d !== ref_mem[addr_of(xs[i], 30)]) begin
        miscompares++;
        $display("FAIL decay_ignored_pixel x=%0d rd_data=%0d required %0d", xs[i], d, ref_mem[addr_of(xs[i], 30)]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_clear();
    int chk [5];
    logic [PIX_W-1:0] d; logic v;
    drive_write(999 % 128, 999 / 128, 5, 0);
    drive_write(1000 % 128, 1000 / 128, 6, 0);
    drive_write(1001 % 128, 1001 / 128, 7, 0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (1000) tick();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (busy !== 1'b0 || sweep_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_clear_reset busy=%b done=%b required 0 0", busy, sweep_done);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (wr_ready !== 1'b1 || busy !== 1'b0 || sweep_done !== 1'b0 || dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL after_abort wr_ready=%b busy=%b done=%b state=%0d required 1 0 0 0",
               wr_ready, busy, sweep_done, dbg_state);
    end
    for (int i = 0; i < 1000; i++) ref_mem[i] = '0;
    chk = '{0, 500, 999, 1000, 1001};
    for (int i = 0; i < 5; i++) begin
      do_read(chk[i] % 128, chk[i] / 128, d, v);
      vectors++;
      if (d !== ref_mem[chk[i]]) begin
        miscompares++;
        $display("FAIL abort_contents addr=%0d rd_data=%0d required %0d", chk[i], d, ref_mem[chk[i]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_modes();
    test_back_to_back();
    test_random();
    test_priority();
    test_decay();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tof_plot_fb.md
# tof_plot_fb

Parametrised single-clock multi-bit framebuffer for the ToF plot, replacing the 1-bit bit-plane store. Accepts plot writes with a valid/ready handshake and per-write combine modes (overwrite, saturating accumulate, max, erase), each done as a read-modify-write. Includes a hardware sweep engine for whole-frame clear. Provides an independent registered read port for the scan-out logic, all in the system clock domain.

## Interface
- X_W, 8, x coordinate width; frame width 2^X_W
- Y_W, 8, y coordinate width; frame height 2^Y_W
- PIX_W, 4, pixel intensity width; PMAX = 2^PIX_W-1
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write may be accepted this cycle
- wr_x  in  X_W  write x
- wr_y  in  Y_W  write y
- wr_data  in  PIX_W  write operand
- wr_mode  in  2  00 overwrite, 01 saturating add, 10 max, 11 erase (write 0)
- rd_en  in  1  read request
- rd_x  in  X_W  read x
- rd_y  in  Y_W  read y
- rd_data  out  PIX_W  pixel read data
- rd_valid  out  1  rd_data valid strobe
- clr_start  in  1  start whole-frame clear sweep
- decay_start  in  1  start whole-frame decay sweep (DECAY feature)
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse after the last sweep write

## Operation
- Address = {y, x}, depth 2^(X_W+Y_W); memory inferred as block RAM. Contents are not reset.
- Write path, 2 cycles per op. Phase R is the accept cycle: sample operands and issue memory read. Phase W is the next cycle: compute new = f(old, wr_data, mode) and write.
  - Overwrite: new = wr_data.
  - Add: new = min(old + wr_data, PMAX), computed PIX_W+1 wide.
  - Max: new = max(old, wr_data).
  - Erase: new = 0.
- wr_ready = !busy && !phase_W && !clr_start && !decay_start. A start pulse takes priority over a same-cycle write.
- Accept = wr_valid && wr_ready. wr_ready is low in phase W, so peak throughput is one op per 2 cycles. A following op at the same address always sees the prior result, so no forwarding is needed.
- Sweep FSM:
  - States: IDLE, CLEAR, DECAY_RD, DECAY_WR, DONE.
  - A start is honoured only in IDLE with phase_W = 0; otherwise it is ignored.
  - clr_start and decay_start in the same cycle: clear wins.
  - CLEAR: writes 0 at counter address, counter increments by 1 per cycle from 0 to 2^(X_W+Y_W)-1, then goes to DONE.
  - DECAY_RD/DECAY_WR: per address, new = (old == 0) ? 0 : old-1; 2 cycles per address.
  - DONE: asserts sweep_done for one cycle, then returns to IDLE.
- Read path is independent of writes and sweeps. A read to an address being written in the same cycle returns the old value (read-first).
- Reset asserted mid-sweep or mid-write aborts the operation. Memory is left partially updated and the FSM goes to IDLE.

## Timing
- Reset values: wr_ready 1 (after rst_n deasserts), rd_data 0, rd_valid 0, busy 0, sweep_done 0, FSM IDLE, sweep counter 0.
- Read latency is 1 cycle: rd_en at edge N gives rd_data and rd_valid=1 at N+1. rd_data holds until the next rd_en.
- Write: accepted at edge N, memory updated at edge N+1, wr_ready high again after edge N+1.
- busy rises on the edge that accepts the start.
- Clear with defaults: busy high for 65,536 cycles; sweep_done pulses on the cycle after the final write; busy low in that same cycle.
- Decay with defaults: 131,072 cycles.

## Configuration
- TOF_PLOT_FB_DECAY_EN defined: decay_start is functional and the DECAY_RD/DECAY_WR states are built, for persistence fade.
- TOF_PLOT_FB_DECAY_EN undefined: decay_start is ignored (port retained), decay states are absent, and wr_ready ignores decay_start.

## Test plan
- Clear then read: clr_start, wait for sweep_done. Reads of (0,0), (255,255), (17,200) -> rd_data 0 one cycle after rd_en. busy high for exactly 65,536 cycles.
- Modes at (3,5):
  - Overwrite 9 -> 9.
  - Add 4 -> 13.
  - Add 7 -> 15 (saturates).
  - Max 2 -> 15.
  - Erase -> 0.
- Handshake: wr_valid held high with 4 ops -> wr_ready toggles 1,0,1,0. Ops land on consecutive odd edges. Back-to-back adds of 1 to the same pixel from 0 give 4.
- Priority: clr_start and wr_valid in the same cycle -> write not accepted, busy=1, wr_ready=0 until sweep_done. clr_start during busy -> ignored, duration unchanged.
- Decay (TOF_PLOT_FB_DECAY_EN): pixels preset to 0, 1, 15 -> 0, 0, 14 after one sweep. Duration 131,072 cycles. Built without the macro: decay_start leaves busy=0 and pixels unchanged.
- Reset mid-clear: rst_n low at sweep count 1000 -> busy=0, sweep_done=0, wr_ready=1 after release. Addresses below 1000 read 0.
